// File: rtl/uart_tx_path_if.sv
// NIC-facing bundle of the UART transmit path: write port, serial line and ring status.
interface uart_tx_path_if #(
  parameter int WORD_SIZE    = 8,
  parameter int TX_RING_SIZE = 16
);
  logic [WORD_SIZE-1:0]             data_in;
  logic                             write_nic;
  logic                             tx;
  logic [$clog2(TX_RING_SIZE):0]    ring_count;
  logic                             ring_empty;
  logic                             ring_full;
  logic                             busy;
  logic                             overflow;

  modport master (
    output data_in, write_nic,
    input  tx, ring_count, ring_empty, ring_full, busy, overflow
  );

  modport slave (
    input  data_in, write_nic,
    output tx, ring_count, ring_empty, ring_full, busy, overflow
  );
endinterface

// File: rtl/uart_tx_path.sv
// UART transmit path: TX ring buffer feeding an 8N1-style serializer that runs
// frames back to back while the ring holds data.
module uart_tx_path #(
  parameter int WORD_SIZE    = 8,
  parameter int TX_RING_SIZE = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_path_if.slave   bus
);

  localparam int PW = $clog2(TX_RING_SIZE);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_SIZE - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(TX_RING_SIZE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [WORD_SIZE-1:0] mem [TX_RING_SIZE];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_n;
  logic                 empty_q;
  logic                 full_q;
  logic                 ovf_q;

  logic [1:0]           state;
  logic [BW-1:0]        bit_cnt;
  logic [IW-1:0]        bit_idx;
  logic [WORD_SIZE-1:0] shift;
  logic [WORD_SIZE-1:0] shift_nxt;
  logic                 tx_q;

  logic                 bit_end;
  logic                 pop;
  logic                 push;

  assign bit_end   = (bit_cnt == BIT_LAST);
  assign shift_nxt = shift >> 1;

  // Pop only from IDLE or the last STOP cycle, and never from an empty ring.
  assign pop  = !empty_q && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  // A full ring still accepts a word when the head leaves on the same edge.
  assign push = bus.write_nic && (!full_q || pop);

  assign count_n = count_q + CW'(push) - CW'(pop);

  // Ring storage holds data only; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // Ring control: pointers, occupancy and registered flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_n;
      empty_q <= (count_n == '0);
      full_q  <= (count_n == CNT_FULL);
      ovf_q   <= bus.write_nic && full_q && !pop;
    end
  end

  // Shift register: loaded on pop, advanced at the end of each data bit
  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= mem[rd_ptr];
    end else if ((state == S_DATA) && bit_end) begin
      shift <= shift_nxt;
    end
  end

  // Serializer FSM; tx is registered so the line never glitches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          tx_q    <= 1'b1;
          if (pop) begin
            state <= S_START;
            tx_q  <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            tx_q    <= shift[0];
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              state <= S_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IW'(1);
              tx_q    <= shift_nxt[0];
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            // Chain straight into the next start bit when more data is waiting.
            if (pop) begin
              state <= S_START;
              tx_q  <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.ring_count = count_q;
  assign bus.ring_empty = empty_q;
  assign bus.ring_full  = full_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_path.sv
// Directed bench for uart_tx_path with WORD_SIZE=8, TX_RING_SIZE=4, CLKS_PER_BIT=4.
module tb_uart_tx_path;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_tx_path_if #(.WORD_SIZE(8), .TX_RING_SIZE(4)) bus ();

  uart_tx_path #(
    .WORD_SIZE   (8),
    .TX_RING_SIZE(4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the start-bit edge of a frame carrying w.
  function automatic logic exp_tx(input logic [7:0] w, input int k);
    if (k < 4)       return 1'b0;
    else if (k < 36) return w[(k - 4) / 4];
    else             return 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    bus.write_nic = 1'b0;
    bus.data_in   = 8'h00;
    repeat (2) tick;
    checks++; if (bus.tx !== 1'b1)         begin failures++; $display("FAIL reset_tx got=%b exp=1", bus.tx); end
    checks++; if (bus.ring_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.ring_count); end
    checks++; if (bus.ring_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.ring_empty); end
    checks++; if (bus.ring_full !== 1'b0)  begin failures++; $display("FAIL reset_full got=%b exp=0", bus.ring_full); end
    checks++; if (bus.busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_idle;
    for (int c = 0; c < 100; c++) begin
      tick;
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.ring_empty !== 1'b1) begin
        failures++;
        $display("FAIL idle cyc=%0d tx=%b busy=%b empty=%b exp tx=1 busy=0 empty=1", c, bus.tx, bus.busy, bus.ring_empty);
      end
    end
  endtask

  task automatic test_single;
    bus.data_in   = 8'hA5;
    bus.write_nic = 1'b1;
    tick;
    bus.write_nic = 1'b0;
    bus.data_in   = 8'h00;
    checks++; if (bus.ring_count !== 3'd1) begin failures++; $display("FAIL single_count_after_write got=%0d exp=1", bus.ring_count); end
    checks++; if (bus.tx !== 1'b1)         begin failures++; $display("FAIL single_tx_before_pop got=%b exp=1", bus.tx); end
    for (int k = 0; k < 40; k++) begin
      tick;
      checks++;
      if (bus.tx !== exp_tx(8'hA5, k) || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL single_frame k=%0d tx=%b busy=%b exp tx=%b busy=1", k, bus.tx, bus.busy, exp_tx(8'hA5, k));
      end
      if (k == 0) begin
        checks++; if (bus.ring_count !== 3'd0) begin failures++; $display("FAIL single_count_after_pop got=%0d exp=0", bus.ring_count); end
      end
    end
    tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1 || bus.ring_empty !== 1'b1) begin
      failures++;
      $display("FAIL single_end busy=%b tx=%b empty=%b exp busy=0 tx=1 empty=1", bus.busy, bus.tx, bus.ring_empty);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w;
    for (int c = 0; c <= 201; c++) begin
      bus.write_nic = (c < 8);
      bus.data_in   = 8'(c);
      tick;
      if (c >= 1 && c <= 200) begin
        w = 8'((c - 1) / 40);
        checks++;
        if (bus.tx !== exp_tx(w, (c - 1) % 40) || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_frame cyc=%0d tx=%b busy=%b exp tx=%b busy=1", c, bus.tx, bus.busy, exp_tx(w, (c - 1) % 40));
        end
      end
      checks++;
      if (bus.overflow !== ((c >= 5 && c <= 7) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL b2b_overflow cyc=%0d got=%b exp=%b", c, bus.overflow, (c >= 5 && c <= 7));
      end
      if (c == 4) begin
        checks++;
        if (bus.ring_count !== 3'd4 || bus.ring_full !== 1'b1) begin
          failures++;
          $display("FAIL b2b_full count=%0d full=%b exp count=4 full=1", bus.ring_count, bus.ring_full);
        end
      end
      if (c == 201) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.ring_empty !== 1'b1 || bus.tx !== 1'b1) begin
          failures++;
          $display("FAIL b2b_end busy=%b empty=%b tx=%b exp busy=0 empty=1 tx=1", bus.busy, bus.ring_empty, bus.tx);
        end
      end
    end
    bus.write_nic = 1'b0;
  endtask

  task automatic test_full_pop_push;
    logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h3C};
    for (int c = 0; c <= 241; c++) begin
      bus.write_nic = (c < 5) || (c == 41);
      bus.data_in   = (c == 41) ? 8'h3C : ((c < 5) ? words[c] : 8'h00);
      tick;
      if (c >= 1 && c <= 240) begin
        checks++;
        if (bus.tx !== exp_tx(words[(c - 1) / 40], (c - 1) % 40)) begin
          failures++;
          $display("FAIL fullpop_frame cyc=%0d tx=%b exp=%b", c, bus.tx, exp_tx(words[(c - 1) / 40], (c - 1) % 40));
        end
      end
      if (c == 40) begin
        checks++;
        if (bus.ring_count !== 3'd4 || bus.ring_full !== 1'b1) begin
          failures++;
          $display("FAIL fullpop_pre count=%0d full=%b exp count=4 full=1", bus.ring_count, bus.ring_full);
        end
      end
      if (c == 41) begin
        checks++;
        if (bus.ring_count !== 3'd4 || bus.overflow !== 1'b0) begin
          failures++;
          $display("FAIL fullpop_edge count=%0d overflow=%b exp count=4 overflow=0", bus.ring_count, bus.overflow);
        end
      end
      if (c == 241) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.ring_empty !== 1'b1) begin
          failures++;
          $display("FAIL fullpop_end busy=%b empty=%b exp busy=0 empty=1", bus.busy, bus.ring_empty);
        end
      end
    end
    bus.write_nic = 1'b0;
  endtask

  task automatic test_stream_wrap;
    logic [7:0] w;
    for (int c = 0; c <= 401; c++) begin
      bus.write_nic = (c % 30 == 0) && (c < 300);
      bus.data_in   = bus.write_nic ? 8'(8'h10 + c / 30) : 8'hFF;
      tick;
      if (c >= 1 && c <= 400) begin
        w = 8'(8'h10 + (c - 1) / 40);
        checks++;
        if (bus.tx !== exp_tx(w, (c - 1) % 40) || bus.overflow !== 1'b0) begin
          failures++;
          $display("FAIL stream_frame cyc=%0d tx=%b overflow=%b exp tx=%b overflow=0", c, bus.tx, bus.overflow, exp_tx(w, (c - 1) % 40));
        end
      end
      if (c == 401) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.ring_empty !== 1'b1 || bus.tx !== 1'b1) begin
          failures++;
          $display("FAIL stream_end busy=%b empty=%b tx=%b exp busy=0 empty=1 tx=1", bus.busy, bus.ring_empty, bus.tx);
        end
      end
    end
    bus.write_nic = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] words [3] = '{8'hA5, 8'h77, 8'h88};
    for (int c = 0; c <= 18; c++) begin
      bus.write_nic = (c < 3);
      bus.data_in   = (c < 3) ? words[c] : 8'h00;
      tick;
    end
    bus.write_nic = 1'b0;
    // Edge 18 lies inside data bit 3 of 0xA5, which is a 0 on the line.
    checks++;
    if (bus.tx !== 1'b0 || bus.ring_count !== 3'd2) begin
      failures++;
      $display("FAIL midreset_pre tx=%b count=%0d exp tx=0 count=2", bus.tx, bus.ring_count);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.tx !== 1'b1 || bus.ring_count !== 3'd0 || bus.busy !== 1'b0 || bus.ring_empty !== 1'b1) begin
      failures++;
      $display("FAIL midreset_now tx=%b count=%0d busy=%b empty=%b exp tx=1 count=0 busy=0 empty=1",
               bus.tx, bus.ring_count, bus.busy, bus.ring_empty);
    end
    tick;
    rst = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick;
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL midreset_after cyc=%0d tx=%b busy=%b exp tx=1 busy=0", c, bus.tx, bus.busy);
      end
    end
  endtask

  initial begin
    bus.write_nic = 1'b0;
    bus.data_in   = 8'h00;
    test_reset;
    test_idle;
    test_single;
    test_back_to_back;
    test_full_pop_push;
    test_stream_wrap;
    test_reset_mid_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
